axis_request_packer: RTL and testbench

AXIS_REQUEST_PACKER -- requirements
Module: axis_request_packer

---
 rtl/axis_request_packer.sv | 129 ++++++++++++
 tb/tb_axis_request_packer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_request_packer.sv
// rtl/axis_request_packer.sv - packs a 9-byte request stream into 72-bit beats
// with a mid-packet idle timeout that discards stalled partial packets.
module axis_request_packer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    output logic [71:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [15:0] DROP_COUNT
);

    // The timer only has to reach TIMEOUT_CYCLES-1: the edge that would take it
    // to TIMEOUT_CYCLES is the discard edge, so it can never wrap.
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        (TIMEOUT_CYCLES > 0) ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [63:0]       buf_q, buf_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;
    logic [71:0]       m_data_q, m_data_d;
    logic [15:0]       drop_q, drop_d;

    logic accept;
    logic last_byte;
    logic idle_cycle;
    logic timeout_hit;

    assign accept      = S_AXIS_TVALID && s_ready_q;
    assign last_byte   = accept && (cnt_q == 4'd8);
    assign idle_cycle  = (state_q == COLLECT) && (cnt_q != 4'd0) && !accept;
    assign timeout_hit = TIMEOUT_EN && idle_cycle && (idle_q == IDLE_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        buf_d     = buf_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        drop_d    = drop_q;

        case (state_q)
            COLLECT: begin
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                if (accept) begin
                    idle_d = '0;
                    if (last_byte) begin
                        m_data_d  = {buf_q, S_AXIS_TDATA};
                        m_valid_d = 1'b1;
                        s_ready_d = 1'b0;
                        cnt_d     = 4'd0;
                        state_d   = EMIT;
                    end else begin
                        // Bytes shift in from the bottom, so byte 1 ends up in [63:56].
                        buf_d = {buf_q[55:0], S_AXIS_TDATA};
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (timeout_hit) begin
                    cnt_d  = 4'd0;
                    idle_d = '0;
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end else if (idle_cycle && TIMEOUT_EN) begin
                    idle_d = idle_q + 1'b1;
                end else begin
                    idle_d = '0;
                end
            end
            EMIT: begin
                idle_d    = '0;
                s_ready_d = 1'b0;
                if (M_AXIS_TREADY) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= COLLECT;
            cnt_q     <= 4'd0;
            idle_q    <= '0;
            buf_q     <= 64'd0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= 72'd0;
            drop_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            buf_q     <= buf_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            drop_q    <= drop_d;
        end
    end

    assign S_AXIS_TREADY = s_ready_q;
    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign DROP_COUNT    = drop_q;

endmodule

// File: tb/tb_axis_request_packer.sv
// tb/tb_axis_request_packer.sv - self-checking bench for axis_request_packer
// (timeouts of 16, 1 and disabled) against a byte-queue reference model.
module tb_axis_request_packer;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  s_tdata = 8'd0;
    logic        m_tready = 1'b0;
    logic        tv16 = 1'b0, tv1 = 1'b0, tv0 = 1'b0;
    logic        sr16, sr1, sr0;
    logic        mv16, mv1, mv0;
    logic [71:0] md16, md1, md0;
    logic [15:0] dc16, dc1, dc0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_request_packer #(.TIMEOUT_CYCLES(16)) u_t16 (
        .clk(clk), .resetn(resetn),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(tv16), .S_AXIS_TREADY(sr16),
        .M_AXIS_TDATA(md16), .M_AXIS_TVALID(mv16), .M_AXIS_TREADY(m_tready),
        .DROP_COUNT(dc16)
    );

    axis_request_packer #(.TIMEOUT_CYCLES(1)) u_t1 (
        .clk(clk), .resetn(resetn),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(tv1), .S_AXIS_TREADY(sr1),
        .M_AXIS_TDATA(md1), .M_AXIS_TVALID(mv1), .M_AXIS_TREADY(m_tready),
        .DROP_COUNT(dc1)
    );

    axis_request_packer #(.TIMEOUT_CYCLES(0)) u_t0 (
        .clk(clk), .resetn(resetn),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(tv0), .S_AXIS_TREADY(sr0),
        .M_AXIS_TDATA(md0), .M_AXIS_TVALID(mv0), .M_AXIS_TREADY(m_tready),
        .DROP_COUNT(dc0)
    );

    function automatic logic ready_of(input int which);
        case (which)
            16:      return sr16;
            1:       return sr1;
            default: return sr0;
        endcase
    endfunction

    task automatic set_valid(input int which, input logic v);
        case (which)
            16:      tv16 = v;
            1:       tv1 = v;
            default: tv0 = v;
        endcase
    endtask

    // Offers one byte and returns at posedge+1 of the edge that accepted it.
    task automatic send_byte(input int which, input logic [7:0] b, output bit ok);
        bit acc;
        ok = 1'b0;
        s_tdata = b;
        set_valid(which, 1'b1);
        for (int n = 0; n < 200; n++) begin
            acc = (ready_of(which) === 1'b1);
            @(posedge clk); #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        set_valid(which, 1'b0);
    endtask

    task automatic send_bytes(input int which, input logic [71:0] v, input int first, input int last);
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        for (int i = first; i <= last; i++) begin
            send_byte(which, v[71-8*i -: 8], ok);
            if (!ok) all_ok = 1'b0;
        end
        checks++;
        if (!all_ok) begin
            failures++;
            $display("FAIL send_stall: dut=%0d bytes %0d..%0d not all accepted within budget", which, first, last);
        end
    endtask

    task automatic drain();
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({sr16, mv16, md16, dc16} !== 90'd0) begin
            failures++;
            $display("FAIL reset_async: got ready=%b valid=%b data=%h drop=%h required all 0", sr16, mv16, md16, dc16);
        end
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        #1;
        checks++;
        if (sr16 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_before_edge: got %b required 0", sr16);
        end
        @(posedge clk); #1;
        checks++;
        if (sr16 !== 1'b1 || sr1 !== 1'b1 || sr0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_first_edge: got %b%b%b required 111", sr16, sr1, sr0);
        end
    endtask

    task automatic test_basic();
        logic [71:0] exp_v;
        exp_v = 72'h01_12345678_AABBCCDD;
        m_tready = 1'b1;
        send_bytes(16, exp_v, 0, 7);
        checks++;
        if (mv16 !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: got %b required 0", mv16);
        end
        send_bytes(16, exp_v, 8, 8);
        checks++;
        if (mv16 !== 1'b1 || md16 !== exp_v) begin
            failures++;
            $display("FAIL basic_beat: got valid=%b data=%h required 1 %h", mv16, md16, exp_v);
        end
        checks++;
        if (sr16 !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_emit: got %b required 0", sr16);
        end
        @(posedge clk); #1;
        checks++;
        if (mv16 !== 1'b0 || sr16 !== 1'b1) begin
            failures++;
            $display("FAIL basic_one_cycle: got valid=%b ready=%b required 0 1", mv16, sr16);
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] p1, p2;
        int bad;
        p1 = 72'hA5_DEADBEEF_01234567;
        p2 = 72'h55_01020304_05060708;
        m_tready = 1'b0;
        send_bytes(16, p1, 0, 8);
        s_tdata = 8'h55;
        tv16 = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (mv16 !== 1'b1 || md16 !== p1 || sr16 !== 1'b0) begin
                failures++;
                bad++;
                if (bad < 4)
                    $display("FAIL bp_hold: cycle %0d got valid=%b ready=%b data=%h required 1 0 %h", c, mv16, sr16, md16, p1);
            end
        end
        m_tready = 1'b1;
        send_bytes(16, p2, 0, 8);
        checks++;
        if (mv16 !== 1'b1 || md16[71:64] !== 8'h55 || md16 !== p2) begin
            failures++;
            $display("FAIL bp_next_packet: got valid=%b data=%h required 1 %h", mv16, md16, p2);
        end
    endtask

    task automatic test_random();
        logic [7:0]  stream[$];
        logic [7:0]  q_exp[$];
        logic [71:0] exp_v, hold_d;
        bit          hold_v, acc_in, acc_out;
        int          npk, sent, got;
        npk = 12;
        sent = 0;
        got = 0;
        drain();
        for (int i = 0; i < npk * 9; i++) stream.push_back(8'($urandom));
        for (int cyc = 0; cyc < 4000 && got < npk; cyc++) begin
            if (!tv16 && sent < npk * 9 && $urandom_range(0, 3) != 0) begin
                s_tdata = stream[sent];
                tv16 = 1'b1;
            end
            m_tready = ($urandom_range(0, 2) != 0);
            acc_in  = tv16 && (sr16 === 1'b1);
            acc_out = (mv16 === 1'b1) && m_tready;
            hold_v  = (mv16 === 1'b1);
            hold_d  = md16;
            @(posedge clk); #1;
            if (acc_in) begin
                q_exp.push_back(stream[sent]);
                sent++;
                tv16 = 1'b0;
            end
            if (acc_out) begin
                checks++;
                if (q_exp.size() < 9) begin
                    failures++;
                    $display("FAIL rnd_early_beat: got beat with %0d bytes queued required 9", q_exp.size());
                end else begin
                    exp_v = '0;
                    for (int k = 0; k < 9; k++) exp_v = {exp_v[63:0], q_exp.pop_front()};
                    if (hold_d !== exp_v) begin
                        failures++;
                        $display("FAIL rnd_beat: packet %0d got %h required %h", got, hold_d, exp_v);
                    end
                end
                got++;
            end else if (hold_v) begin
                checks++;
                if (mv16 !== 1'b1 || md16 !== hold_d) begin
                    failures++;
                    $display("FAIL rnd_hold: got valid=%b data=%h required 1 %h", mv16, md16, hold_d);
                end
            end
        end
        tv16 = 1'b0;
        checks++;
        if (got != npk || dc16 !== 16'd0) begin
            failures++;
            $display("FAIL rnd_count: got packets=%0d drops=%0d required %0d 0", got, dc16, npk);
        end
    endtask

    task automatic test_reset_mid();
        logic [71:0] fresh;
        fresh = 72'h7E_CAFEF00D_13579BDF;
        drain();
        send_bytes(16, 72'hFF_EEDDCCBB_AA998877, 0, 4);
        resetn = 1'b0;
        #1;
        checks++;
        if ({sr16, mv16, md16, dc16} !== 90'd0) begin
            failures++;
            $display("FAIL rst_mid_packet: got ready=%b valid=%b data=%h drop=%h required all 0", sr16, mv16, md16, dc16);
        end
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        send_bytes(16, 72'h11_22334455_66778899, 0, 8);
        resetn = 1'b0;
        #1;
        checks++;
        if (mv16 !== 1'b0 || md16 !== 72'd0 || dc16 !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid_emit: got valid=%b data=%h drop=%h required 0 0 0", mv16, md16, dc16);
        end
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b1;
        send_bytes(16, fresh, 0, 8);
        checks++;
        if (mv16 !== 1'b1 || md16 !== fresh || dc16 !== 16'd0) begin
            failures++;
            $display("FAIL rst_fresh_packet: got valid=%b data=%h drop=%h required 1 %h 0", mv16, md16, dc16, fresh);
        end
    endtask

    task automatic test_timeout_boundary();
        logic [71:0] p;
        p = 72'h03_11223344_55667788;
        drain();
        send_bytes(16, p, 0, 3);
        repeat (15) @(posedge clk);
        #1;
        send_bytes(16, p, 4, 8);
        checks++;
        if (mv16 !== 1'b1 || md16 !== p || dc16 !== 16'd0) begin
            failures++;
            $display("FAIL to_boundary: got valid=%b data=%h drop=%h required 1 %h 0", mv16, md16, dc16, p);
        end
    endtask

    task automatic test_timeout();
        logic [71:0] p;
        bit saw_valid;
        p = 72'h02_00001000_0000002A;
        drain();
        send_bytes(16, 72'h99_88776655_44332211, 0, 3);
        saw_valid = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (mv16 !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (dc16 !== 16'd0) begin
            failures++;
            $display("FAIL to_15_idle: got drop=%0d required 0", dc16);
        end
        @(posedge clk); #1;
        if (mv16 !== 1'b0) saw_valid = 1'b1;
        checks++;
        if (dc16 !== 16'd1 || saw_valid) begin
            failures++;
            $display("FAIL to_16_idle: got drop=%0d saw_valid=%b required 1 0", dc16, saw_valid);
        end
        send_bytes(16, p, 0, 8);
        checks++;
        if (mv16 !== 1'b1 || md16 !== p || dc16 !== 16'd1) begin
            failures++;
            $display("FAIL to_next_packet: got valid=%b data=%h drop=%0d required 1 %h 1", mv16, md16, dc16, p);
        end
    endtask

    task automatic test_timeout_disabled();
        logic [71:0] p;
        p = 72'hC3_0BADF00D_76543210;
        drain();
        send_bytes(0, p, 0, 3);
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (dc0 !== 16'd0 || mv0 !== 1'b0) begin
            failures++;
            $display("FAIL nto_wait: got drop=%0d valid=%b required 0 0", dc0, mv0);
        end
        send_bytes(0, p, 4, 8);
        checks++;
        if (mv0 !== 1'b1 || md0 !== p || dc0 !== 16'd0) begin
            failures++;
            $display("FAIL nto_packet: got valid=%b data=%h drop=%0d required 1 %h 0", mv0, md0, dc0, p);
        end
    endtask

    task automatic test_saturation();
        bit saw_valid;
        int n_drop;
        saw_valid = 1'b0;
        n_drop = 65537;
        for (int i = 1; i <= n_drop; i++) begin
            s_tdata = 8'(i);
            tv1 = 1'b1;
            @(posedge clk); #1;
            tv1 = 1'b0;
            @(posedge clk); #1;
            if (mv1 !== 1'b0) saw_valid = 1'b1;
            if (i == 3 || i == 65534) begin
                checks++;
                if (dc1 !== 16'(i)) begin
                    failures++;
                    $display("FAIL sat_progress: after %0d got %0d required %0d", i, dc1, i);
                end
            end
        end
        checks++;
        if (dc1 !== 16'hFFFF || saw_valid) begin
            failures++;
            $display("FAIL sat_final: got drop=%h saw_valid=%b required ffff 0", dc1, saw_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_timeout_boundary();
        test_timeout();
        test_timeout_disabled();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
